// File: rtl/gpio_frame_capture.sv
// GPIO pixel stream capture into a raster-order frame buffer with a registered read port.
// Optional per-frame checksum output is enabled by defining CAPTURE_CHECKSUM_EN.
module gpio_frame_capture #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240,
  parameter int PIX_W  = 1,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  gpio_data,
  input  logic              gpio_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              done,
  output logic [ADDR_W-1:0] pix_count,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] row,
  output logic              overflow,
`ifdef CAPTURE_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: one pixel is accepted on every rising edge where gpio_valid=1 while
  // capturing and start=0; there is no back-pressure, so the source never waits.

  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  mem [0:DEPTH-1];
  logic              take;
  logic              last;
  logic              col_end;
  logic              row_end;

  assign take    = (state == ST_CAPTURE) && gpio_valid && !start;
  assign last    = take && (pix_count == ADDR_W'(DEPTH - 1));
  assign col_end = (col == ADDR_W'(WIDTH - 1));
  assign row_end = (row == ADDR_W'(HEIGHT - 1));

  assign busy      = (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pix_count  <= '0;
      wr_addr    <= '0;
      col        <= '0;
      row        <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last;
      if (start) begin
        // start wins over a coincident strobe and always begins a fresh frame
        state     <= ST_CAPTURE;
        pix_count <= '0;
        wr_addr   <= '0;
        col       <= '0;
        row       <= '0;
        overflow  <= 1'b0;
      end else begin
        case (state)
          ST_CAPTURE: begin
            if (take) begin
              pix_count <= pix_count + ADDR_W'(1);
              wr_addr   <= wr_addr + ADDR_W'(1);
              if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ADDR_W'(1);
              end else begin
                col <= col + ADDR_W'(1);
              end
              if (last) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (gpio_valid) overflow <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Frame buffer: contents survive reset so a readback block can still see the last frame
  always_ff @(posedge clk) begin
    if (take) mem[wr_addr[MEM_AW-1:0]] <= gpio_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr[MEM_AW-1:0]];
  end

`ifdef CAPTURE_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start) checksum <= '0;
    else if (take)      checksum <= checksum + 16'(gpio_data);
  end
`endif

endmodule

// File: tb/tb_gpio_frame_capture.sv
// Self-checking bench for gpio_frame_capture on a 4x3 frame with 8-bit pixels.
module tb_gpio_frame_capture;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = WIDTH * HEIGHT;

  logic              clk = 1'b0;
  logic              reset, start, gpio_valid;
  logic [PIX_W-1:0]  gpio_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              busy, frame_done, done, overflow;
  logic [ADDR_W-1:0] pix_count, col, row;
  logic [1:0]        state_dbg;
`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  gpio_frame_capture #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .gpio_data(gpio_data), .gpio_valid(gpio_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_done(frame_done), .done(done),
    .pix_count(pix_count), .col(col), .row(row), .overflow(overflow),
`ifdef CAPTURE_CHECKSUM_EN
    .checksum(checksum),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fd_count = 0;

  // reference model
  logic [PIX_W-1:0] exp_mem [0:DEPTH-1];
  logic [PIX_W-1:0] exp_q [$];
  int               m_state = 0;   // 0 idle, 1 capture, 2 done
  int               m_cnt = 0;
  logic             m_ovf = 1'b0;
  int               m_sum = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_state = 1; m_cnt = 0; m_ovf = 1'b0; m_sum = 0;
  endtask

  task automatic strobe(input logic [PIX_W-1:0] d);
    gpio_valid = 1'b1;
    gpio_data  = d;
    tick();
    gpio_valid = 1'b0;
    if (m_state == 1) begin
      exp_mem[m_cnt] = d;
      m_sum = (m_sum + int'(d)) % 65536;
      m_cnt++;
      if (m_cnt == DEPTH) m_state = 2;
    end else if (m_state == 2) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic check_counters(input string name);
    total++;
    if (pix_count !== ADDR_W'(m_cnt) || col !== ADDR_W'(m_cnt % WIDTH) ||
        row !== ADDR_W'((m_cnt / WIDTH) % HEIGHT)) begin
      bad++;
      $display("FAIL %s: pix_count=%0d col=%0d row=%0d required cnt=%0d col=%0d row=%0d", name,
               pix_count, col, row, m_cnt, m_cnt % WIDTH, (m_cnt / WIDTH) % HEIGHT);
    end
    total++;
    if (busy !== (m_state == 1) || done !== (m_state == 2) || overflow !== m_ovf) begin
      bad++;
      $display("FAIL %s flags: busy=%b done=%b overflow=%b required %b %b %b", name, busy, done,
               overflow, m_state == 1, m_state == 2, m_ovf);
    end
  endtask

  task automatic read_sweep(input string name);
    logic [PIX_W-1:0] e;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = ADDR_W'(a);
      exp_q.push_back(exp_mem[a]);
      tick();
      e = exp_q.pop_front();
      total++;
      if (rd_data !== e) begin
        bad++;
        $display("FAIL %s addr %0d: rd_data=%h required %h", name, a, rd_data, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; gpio_valid = 1'b0; gpio_data = '0; rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    total++;
    if (rd_data !== '0 || frame_done !== 1'b0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset: rd_data=%h frame_done=%b state=%0d required 0 0 0",
               rd_data, frame_done, state_dbg);
    end
    check_counters("reset");
  endtask

  task automatic test_frame();
    int fd0;
    do_start();
    check_counters("frame_start");
    fd0 = fd_count;
    for (int i = 0; i < DEPTH; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      strobe(PIX_W'(i & 1));
      if (i == DEPTH - 1) begin
        total++;
        if (frame_done !== 1'b1) begin
          bad++;
          $display("FAIL frame_done_pulse: frame_done=%b required 1", frame_done);
        end
      end
    end
    check_counters("frame_end");
    tick();
    total++;
    if (frame_done !== 1'b0 || fd_count - fd0 != 1) begin
      bad++;
      $display("FAIL frame_done_once: frame_done=%b pulses=%0d required 0 and 1",
               frame_done, fd_count - fd0);
    end
    read_sweep("frame_read");
  endtask

  task automatic test_overflow();
    strobe(8'hAA);
    strobe(8'h55);
    check_counters("overflow");
    read_sweep("overflow_read");
    do_start();
    check_counters("overflow_clear");
  endtask

  task automatic test_back_to_back();
    logic [PIX_W-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      // read the very address being written: old contents must come back
      rd_addr = ADDR_W'(m_cnt);
      exp_q.push_back(exp_mem[m_cnt]);
      strobe(PIX_W'($urandom_range(0, 255)));
      e = exp_q.pop_front();
      total++;
      if (rd_data !== e) begin
        bad++;
        $display("FAIL read_old_data pix %0d: rd_data=%h required %h", i, rd_data, e);
      end
    end
    check_counters("back_to_back");
    read_sweep("back_to_back_read");
  endtask

  task automatic test_start_collision();
    do_start();
    for (int i = 0; i < 5; i++) strobe(PIX_W'(8'h30 + i));
    check_counters("collide_pre");
    start = 1'b1; gpio_valid = 1'b1; gpio_data = 8'hEE;
    tick();
    start = 1'b0; gpio_valid = 1'b0;
    m_cnt = 0; m_sum = 0; m_ovf = 1'b0;
    check_counters("collide_start");
    strobe(8'h77);
    check_counters("collide_next");
    read_sweep("collide_read");
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 7; i++) strobe(PIX_W'(8'hC0 + i));
    check_counters("reset_mid_pre");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_state = 0; m_cnt = 0; m_ovf = 1'b0;
    total++;
    if (rd_data !== '0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: rd_data=%h state=%0d required 0 0", rd_data, state_dbg);
    end
    check_counters("reset_mid");
    read_sweep("reset_mid_read");
  endtask

  task automatic test_idle_strobes();
    for (int i = 0; i < 4; i++) strobe(PIX_W'(8'hF0 + i));
    check_counters("idle_strobes");
    read_sweep("idle_read");
  endtask

`ifdef CAPTURE_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    total++;
    if (checksum !== 16'd0) begin
      bad++;
      $display("FAIL checksum_clear: checksum=%0d required 0", checksum);
    end
    for (int i = 0; i < DEPTH; i++) strobe(PIX_W'(10 + i));
    strobe(8'h99);
    total++;
    if (checksum !== 16'd186 || checksum !== 16'(m_sum)) begin
      bad++;
      $display("FAIL checksum: checksum=%0d required 186", checksum);
    end
    check_counters("checksum_frame");
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_overflow();
    test_back_to_back();
    test_start_collision();
    test_reset_mid();
    test_idle_strobes();
`ifdef CAPTURE_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
